// File: rtl/segre_rf_recovery_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : segre_rf_recovery_ctrl_if
// Description : Bundle between the pipeline (master) and the register-file
//               recovery controller (slave): history pushes, checkpoint
//               commit/rollback requests and the recovery write port/status.
// Revision    : 1.0 - initial release
// ============================================================================
interface segre_rf_recovery_ctrl_if #(
    parameter int HIST_DEPTH = 8,
    parameter int REG_SIZE   = 5,
    parameter int WORD_SIZE  = 32
);
    localparam int CW = $clog2(HIST_DEPTH + 1);

    logic                 hist_push_i;
    logic [REG_SIZE-1:0]  hist_reg_i;
    logic [WORD_SIZE-1:0] hist_data_i;
    logic                 commit_i;
    logic                 rollback_i;
    logic                 recovering_o;
    logic [REG_SIZE-1:0]  reg_recovered_o;
    logic [WORD_SIZE-1:0] data_recovered_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 full_o;
    logic                 overflow_o;
    logic [CW-1:0]        count_o;

    modport master (
        output hist_push_i, hist_reg_i, hist_data_i, commit_i, rollback_i,
        input  recovering_o, reg_recovered_o, data_recovered_o,
        input  busy_o, done_o, full_o, overflow_o, count_o
    );

    modport slave (
        input  hist_push_i, hist_reg_i, hist_data_i, commit_i, rollback_i,
        output recovering_o, reg_recovered_o, data_recovered_o,
        output busy_o, done_o, full_o, overflow_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/segre_rf_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : segre_rf_recovery_ctrl
// Description : Register-file history buffer (LIFO of {reg, old data}).
//               On rollback the held entries are replayed newest-first as
//               recovery writes, followed by a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module segre_rf_recovery_ctrl #(
    parameter int HIST_DEPTH = 8,
    parameter int REG_SIZE   = 5,
    parameter int WORD_SIZE  = 32
) (
    input  wire logic              clk_i,
    input  wire logic              rsn_i,
    segre_rf_recovery_ctrl_if.slave bus
);
    localparam int AW = $clog2(HIST_DEPTH);
    localparam int CW = $clog2(HIST_DEPTH + 1);
    localparam int EW = REG_SIZE + WORD_SIZE;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECOVER = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 recovering_q, recovering_d;
    logic [REG_SIZE-1:0]  reg_q, reg_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [EW-1:0]        mem_q [HIST_DEPTH];
    logic                 wr_en;
    logic [AW-1:0]        wr_idx;
    logic [AW-1:0]        top_idx;
    logic [EW-1:0]        top_entry;
    logic                 push_ok;
    logic                 is_full;

    // x0 is hard-wired, so its old value never needs to be restored
    assign push_ok   = bus.hist_push_i && (bus.hist_reg_i != '0);
    assign is_full   = (count_q == CW'(HIST_DEPTH));
    assign top_idx   = AW'(count_q - CW'(1));
    assign top_entry = mem_q[top_idx];

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            recovering_q <= 1'b0;
            reg_q        <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            recovering_q <= recovering_d;
            reg_q        <= reg_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // History storage; contents are don't-care until the count covers them
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= {bus.hist_reg_i, bus.hist_data_i};
        end
    end

    // Next-state: rollback leaves IDLE, RECOVER drains to DONE, DONE is one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.rollback_i) begin
                    state_d = (count_q != '0) ? ST_RECOVER : ST_DONE;
                end
            end
            ST_RECOVER: begin
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath: the first pop is taken on the rollback edge itself so
    // the registered strobe appears the very next cycle
    always_comb begin
        count_d      = count_q;
        overflow_d   = overflow_q;
        recovering_d = 1'b0;
        reg_d        = '0;
        data_d       = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = AW'(count_q);
        case (state_q)
            ST_IDLE: begin
                if (bus.rollback_i) begin
                    busy_d = 1'b1;
                    if (count_q != '0) begin
                        recovering_d = 1'b1;
                        reg_d        = top_entry[EW-1 -: REG_SIZE];
                        data_d       = top_entry[WORD_SIZE-1:0];
                        count_d      = count_q - CW'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (bus.commit_i) begin
                    // Commit empties the buffer; a same-cycle push lands in slot 0
                    overflow_d = 1'b0;
                    wr_en      = push_ok;
                    wr_idx     = '0;
                    count_d    = push_ok ? CW'(1) : '0;
                end else if (push_ok) begin
                    if (!is_full) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            ST_RECOVER: begin
                busy_d = 1'b1;
                if (count_q != '0) begin
                    recovering_d = 1'b1;
                    reg_d        = top_entry[EW-1 -: REG_SIZE];
                    data_d       = top_entry[WORD_SIZE-1:0];
                    count_d      = count_q - CW'(1);
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.recovering_o     = recovering_q;
    assign bus.reg_recovered_o  = reg_q;
    assign bus.data_recovered_o = data_q;
    assign bus.busy_o           = busy_q;
    assign bus.done_o           = done_q;
    assign bus.full_o           = is_full;
    assign bus.overflow_o       = overflow_q;
    assign bus.count_o          = count_q;

endmodule
`default_nettype wire

// File: tb/tb_segre_rf_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_segre_rf_recovery_ctrl
// Description : Directed bench; expected recovery strobes and done pulses are
//               queued by the stimulus and checked by an output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segre_rf_recovery_ctrl;
    logic clk_i;
    logic rsn_i;

    segre_rf_recovery_ctrl_if #(.HIST_DEPTH(8), .REG_SIZE(5), .WORD_SIZE(32)) bus ();

    segre_rf_recovery_ctrl #(.HIST_DEPTH(8), .REG_SIZE(5), .WORD_SIZE(32)) dut (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .bus   (bus)
    );

    typedef struct {
        logic        rec;
        logic        done;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic exp_strobe(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.rec = 1'b1; e.done = 1'b0; e.r = r; e.d = d;
        sb_q.push_back(e);
    endtask

    task automatic exp_done();
        exp_t e;
        e.rec = 1'b0; e.done = 1'b1; e.r = '0; e.d = '0;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        bus.hist_push_i = 1'b1;
        bus.hist_reg_i  = r;
        bus.hist_data_i = d;
        step();
        bus.hist_push_i = 1'b0;
        bus.hist_reg_i  = '0;
        bus.hist_data_i = '0;
    endtask

    task automatic rollback();
        bus.rollback_i = 1'b1;
        step();
        bus.rollback_i = 1'b0;
    endtask

    task automatic commit();
        bus.commit_i = 1'b1;
        step();
        bus.commit_i = 1'b0;
    endtask

    // Waits until busy drops; n returns the number of busy cycles seen
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy_o) break;
            n++;
            step();
        end
        if (bus.busy_o) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: every strobe or done pulse must match the head of the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (bus.recovering_o || bus.done_o) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: rec=%0d done=%0d reg=%0d data=0x%0h expected none",
                             bus.recovering_o, bus.done_o, bus.reg_recovered_o, bus.data_recovered_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("mon_recovering", 32'(bus.recovering_o), 32'(e.rec));
                    chk("mon_done",       32'(bus.done_o),       32'(e.done));
                    chk("mon_reg",        32'(bus.reg_recovered_o), 32'(e.r));
                    chk("mon_data",       bus.data_recovered_o,  e.d);
                    chk("mon_busy",       32'(bus.busy_o),       32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rsn_i           = 1'b0;
        bus.hist_push_i = 1'b0;
        bus.hist_reg_i  = '0;
        bus.hist_data_i = '0;
        bus.commit_i    = 1'b0;
        bus.rollback_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rsn_i = 1'b1;
        step();

        // Reset state
        chk("rst_count",      32'(bus.count_o),      32'd0);
        chk("rst_full",       32'(bus.full_o),       32'd0);
        chk("rst_overflow",   32'(bus.overflow_o),   32'd0);
        chk("rst_busy",       32'(bus.busy_o),       32'd0);
        chk("rst_recovering", 32'(bus.recovering_o), 32'd0);
        chk("rst_done",       32'(bus.done_o),       32'd0);

        // Basic LIFO replay, newest first
        push(5'd3, 32'hA);
        push(5'd7, 32'hB);
        push(5'd3, 32'hC);
        chk("basic_count", 32'(bus.count_o), 32'd3);
        exp_strobe(5'd3, 32'hC);
        exp_strobe(5'd7, 32'hB);
        exp_strobe(5'd3, 32'hA);
        exp_done();
        rollback();
        chk("basic_first_strobe", 32'(bus.recovering_o), 32'd1);
        chk("basic_first_reg",    32'(bus.reg_recovered_o), 32'd3);
        chk("basic_count_dec",    32'(bus.count_o), 32'd2);
        wait_idle(n);
        chk("basic_busy_cycles", 32'(n), 32'd4);
        chk("basic_end_count",   32'(bus.count_o), 32'd0);

        // Fill, overflow, rollback with overflow held, then commit
        for (int i = 1; i <= 8; i++) push(5'(i), 32'h100 + 32'(i));
        chk("fill_full",      32'(bus.full_o),     32'd1);
        chk("fill_count",     32'(bus.count_o),    32'd8);
        chk("fill_overflow0", 32'(bus.overflow_o), 32'd0);
        push(5'd9, 32'h109);
        chk("ovf_overflow", 32'(bus.overflow_o), 32'd1);
        chk("ovf_count",    32'(bus.count_o),    32'd8);
        for (int i = 8; i >= 1; i--) exp_strobe(5'(i), 32'h100 + 32'(i));
        exp_done();
        rollback();
        step();
        wait_idle(n);
        chk("ovf_rb_count",    32'(bus.count_o),    32'd0);
        chk("ovf_rb_overflow", 32'(bus.overflow_o), 32'd1);
        commit();
        chk("commit_overflow", 32'(bus.overflow_o), 32'd0);
        chk("commit_count",    32'(bus.count_o),    32'd0);
        chk("commit_full",     32'(bus.full_o),     32'd0);

        // Push to x0 ignored; empty rollback gives done only
        push(5'd0, 32'h5);
        chk("x0_count", 32'(bus.count_o), 32'd0);
        exp_done();
        rollback();
        chk("empty_done",       32'(bus.done_o),       32'd1);
        chk("empty_recovering", 32'(bus.recovering_o), 32'd0);
        step();
        chk("empty_busy_after", 32'(bus.busy_o), 32'd0);

        // Commit with simultaneous push keeps only that push
        push(5'd1, 32'h11);
        push(5'd2, 32'h22);
        bus.hist_push_i = 1'b1;
        bus.hist_reg_i  = 5'd4;
        bus.hist_data_i = 32'h1;
        commit();
        bus.hist_push_i = 1'b0;
        bus.hist_reg_i  = '0;
        bus.hist_data_i = '0;
        chk("cpush_count", 32'(bus.count_o), 32'd1);
        exp_strobe(5'd4, 32'h1);
        exp_done();
        rollback();
        wait_idle(n);
        chk("cpush_busy_cycles", 32'(n), 32'd2);

        // Requests during RECOVER are ignored
        for (int i = 5; i <= 8; i++) push(5'(i), 32'h200 + 32'(i));
        for (int i = 8; i >= 5; i--) exp_strobe(5'(i), 32'h200 + 32'(i));
        exp_done();
        rollback();
        bus.hist_push_i = 1'b1;
        bus.hist_reg_i  = 5'd9;
        bus.hist_data_i = 32'hDEAD;
        bus.commit_i    = 1'b1;
        bus.rollback_i  = 1'b1;
        repeat (3) step();
        bus.hist_push_i = 1'b0;
        bus.hist_reg_i  = '0;
        bus.hist_data_i = '0;
        bus.commit_i    = 1'b0;
        bus.rollback_i  = 1'b0;
        wait_idle(n);
        chk("ign_count", 32'(bus.count_o), 32'd0);
        repeat (2) step();

        // Commit and rollback together: rollback wins
        push(5'd10, 32'h77);
        exp_strobe(5'd10, 32'h77);
        exp_done();
        bus.commit_i = 1'b1;
        rollback();
        bus.commit_i = 1'b0;
        wait_idle(n);
        chk("cr_count", 32'(bus.count_o), 32'd0);

        // Reset in the middle of recovery
        for (int i = 11; i <= 14; i++) push(5'(i), 32'hD0 + 32'(i));
        exp_strobe(5'd14, 32'hDE);
        exp_strobe(5'd13, 32'hDD);
        rollback();
        step();
        @(negedge clk_i);
        #1;
        rsn_i = 1'b0;
        #1;
        chk("arst_recovering", 32'(bus.recovering_o), 32'd0);
        chk("arst_busy",       32'(bus.busy_o),       32'd0);
        chk("arst_done",       32'(bus.done_o),       32'd0);
        chk("arst_reg",        32'(bus.reg_recovered_o), 32'd0);
        chk("arst_data",       bus.data_recovered_o,  32'd0);
        chk("arst_count",      32'(bus.count_o),      32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rsn_i = 1'b1;
        repeat (6) step();
        chk("arst_after_busy",  32'(bus.busy_o),  32'd0);
        chk("arst_after_count", 32'(bus.count_o), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
